mont_reduce: RTL and testbench

MONT_REDUCE -- requirements
Module: mont_reduce

---
 rtl/mont_pkg.sv | 14 +
 rtl/mont_half_step.sv | 23 ++
 rtl/mont_reduce.sv | 110 +++++++++++
 tb/tb_mont_reduce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery conversion blocks.
// Also consumed by the to-Montgomery converter.
package mont_pkg;

    localparam int WIDTH = 2048;
    localparam int LEN_W = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mont_half_step.sv
// One bit-serial REDC step: (t + t[0]*n) >> 1 at WIDTH+1 bits.
module mont_half_step #(
    parameter int WIDTH = mont_pkg::WIDTH
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   half
);

    logic [WIDTH:0] addend;

    // floor((t+n)/2) = (t>>1) + (n>>1) + (t[0] & n[0]) when t is odd,
    // which keeps the sum inside WIDTH+1 bits without a carry-out.
    always_comb begin
        addend = '0;
        if (t[0]) begin
            addend = {2'b00, n[WIDTH-1:1]} + {{WIDTH{1'b0}}, n[0]};
        end
    end

    assign half = {1'b0, t[WIDTH:1]} + addend;

endmodule

// File: rtl/mont_reduce.sv
// Bit-serial Montgomery reduction: result = x * 2^-(n_len+1) mod n.
// Define MONT_REDUCE_CHECK_EN to reject even n or x >= n with err.
module mont_reduce #(
    parameter int WIDTH = mont_pkg::WIDTH,
    parameter int LEN_W = mont_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    input  logic [LEN_W-1:0] n_len,
    output logic [WIDTH-1:0] result,
    output logic             finish,
    output logic             busy,
    output logic             err
);

    import mont_pkg::*;

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   t_next;
    logic [WIDTH-1:0] nr;
    logic [LEN_W:0]   cnt;
    logic             ge;
    logic [WIDTH-1:0] fixed;

    mont_half_step #(.WIDTH(WIDTH)) u_step (
        .t    (t),
        .n    (nr),
        .half (t_next)
    );

    // t < 2n, so t - n fits in WIDTH bits whenever it is taken
    assign ge    = t >= {1'b0, nr};
    assign fixed = ge ? t[WIDTH-1:0] - nr : t[WIDTH-1:0];

`ifdef MONT_REDUCE_CHECK_EN
    logic bad;
    logic rej;
    assign bad = ~n[0] | (x >= n);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            t      <= '0;
            nr     <= '0;
            cnt    <= '0;
            result <= '0;
            finish <= 1'b0;
            busy   <= 1'b0;
`ifdef MONT_REDUCE_CHECK_EN
            rej    <= 1'b0;
            err    <= 1'b0;
`endif
        end else begin
            finish <= 1'b0;
`ifdef MONT_REDUCE_CHECK_EN
            err    <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        t    <= {1'b0, x};
                        nr   <= n;
                        cnt  <= {1'b0, n_len} + CNT_ONE;
                        busy <= 1'b1;
`ifdef MONT_REDUCE_CHECK_EN
                        rej   <= bad;
                        state <= bad ? S_FIX : S_ITER;
`else
                        state <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    t   <= t_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef MONT_REDUCE_CHECK_EN
                    if (!rej) begin
                        result <= fixed;
                    end
                    err <= rej;
`else
                    result <= fixed;
`endif
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_reduce.sv
// Scoreboard bench for mont_reduce against a modular-inverse reference.
module tb_mont_reduce;

    localparam int W  = 32;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  n = 32'd1;
    logic [LW-1:0] n_len = '0;
    logic [W-1:0]  result;
    logic          finish;
    logic          busy;
    logic          err;

    mont_reduce #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x      (x),
        .n      (n),
        .n_len  (n_len),
        .result (result),
        .finish (finish),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           at;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           compared = 0;
    int           mismatched = 0;
    logic [W-1:0] last_res = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // x * (2^-1 mod n)^(len+1) mod n, with 2^-1 mod n = (n+1)/2 for odd n
    function automatic logic [W-1:0] ref_redc(logic [W-1:0] xv,
                                              logic [W-1:0] nv, int len);
        longint unsigned nn, inv2, r;
        nn   = nv;
        inv2 = (nn + 1) / 2;
        r    = xv % nn;
        for (int i = 0; i <= len; i++) r = (r * inv2) % nn;
        return r[W-1:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && finish) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_finish: result %0h at t=%0t",
                         result, $time);
            end else begin
                mon_e = q.pop_front();
                chk("result", result, mon_e.res);
                chk("err", err, mon_e.err);
                chk("latency", cyc, mon_e.at);
                chk("busy_at_finish", busy, 0);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge k)
    task automatic issue(logic [W-1:0] xv, logic [W-1:0] nv, int len,
                         bit rejected);
        exp_t e;
        x     = xv;
        n     = nv;
        n_len = len[LW-1:0];
        start = 1'b1;
        e.at  = cyc + 1 + (rejected ? 1 : len + 2);
        e.err = rejected;
        e.res = rejected ? last_res : ref_redc(xv, nv, len);
        last_res = e.res;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        x     = $urandom;
        n     = $urandom;
        n_len = LW'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_finish();
        int b = 0;
        while (!finish && b < 100) begin
            @(negedge clk);
            b++;
        end
        compared++;
        if (!finish) begin
            mismatched++;
            $display("FAIL finish_timeout: got none expected pulse");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] msb;
        logic [W-1:0] rn;
        logic [W-1:0] rx;
        int           len;

        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_finish", finish, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        issue(32'd3, 32'd13, 3, 0);
        wait_finish();
        issue(32'd5, 32'd13, 3, 0);
        wait_finish();

        issue(32'd0, 32'd13, 3, 0);
        wait_finish();
        issue(32'd7, 32'd13, 3, 0);
        wait_finish();

        issue(32'd9, 32'd13, 3, 0);
        start = 1'b1;
        x     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_finish();

        issue(32'd6, 32'd13, 3, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_finish", finish, 0);
        q.delete();
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(32'd6, 32'd13, 3, 0);
        wait_finish();

        issue(32'd0, 32'd1, 0, 0);
        wait_finish();
        issue(32'd2, 32'd3, 1, 0);
        wait_finish();

`ifdef MONT_REDUCE_CHECK_EN
        issue(32'd5, 32'd12, 3, 1);
        wait_finish();
        issue(32'd14, 32'd13, 3, 1);
        wait_finish();
`endif

        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(0, LW == 5 ? 31 : 0);
            msb = 1 << len;
            rn  = msb | ($urandom & (msb - 1)) | 32'd1;
            rx  = $urandom % rn;
            issue(rx, rn, len, 0);
            wait_finish();
            if ($urandom_range(0, 1) == 1) repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
